// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state encoding and frame length.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DPS   = 2'd1,
    CHECK = 2'd2
  } ps2_state_t;

  localparam int unsigned FRAME_LEN = 11;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead FIFO for received PS/2 bytes; DEPTH must be a power of two.
module ps2_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_rd = rd & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign do_wr = wr & (~full | do_rd);
  assign dout  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver with clock glitch filter, frame timeout and byte FIFO.
// Odd-parity checking is enabled by defining PS2_RX_PARITY_EN.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overrun
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  ps2_state_t             state;
  logic [FILTER_LEN-1:0]  filter_reg;
  logic                   f_ps2c_reg;
  logic                   f_ps2c_next;
  logic                   fall_edge;
  logic [FRAME_LEN-1:0]   b_reg;
  logic [FRAME_LEN-1:0]   frame_next;
  logic [3:0]             n_reg;
  logic [TW-1:0]          t_reg;
  logic                   stop_bad;
  logic                   parity_bad;
  logic                   unused_start;

  always_comb begin
    f_ps2c_next = f_ps2c_reg;
    if (filter_reg == '1)      f_ps2c_next = 1'b1;
    else if (filter_reg == '0) f_ps2c_next = 1'b0;
  end

  assign fall_edge = f_ps2c_reg & ~f_ps2c_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      filter_reg <= '0;
      f_ps2c_reg <= 1'b0;
    end else begin
      filter_reg <= {ps2c, filter_reg[FILTER_LEN-1:1]};
      f_ps2c_reg <= f_ps2c_next;
    end
  end

  // The frame is judged as the stop bit shifts in, so the pulses are
  // registered and coincide with the single CHECK cycle.
  assign frame_next = {ps2d, b_reg[FRAME_LEN-1:1]};
  assign stop_bad   = ~ps2d;
`ifdef PS2_RX_PARITY_EN
  assign parity_bad = ~(^frame_next[9:1]);
`else
  assign parity_bad = 1'b0;
`endif
  assign unused_start = b_reg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      b_reg        <= '0;
      n_reg        <= '0;
      t_reg        <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          t_reg <= '0;
          if (fall_edge && rx_en && !ps2d) begin
            b_reg <= frame_next;
            n_reg <= 4'd9;
            state <= DPS;
          end
        end
        DPS: begin
          if (fall_edge) begin
            b_reg <= frame_next;
            t_reg <= '0;
            if (n_reg == 4'd0) begin
              state        <= CHECK;
              frame_err    <= stop_bad;
              parity_err   <= parity_bad;
              rx_done_tick <= ~stop_bad & ~parity_bad;
            end else begin
              n_reg <= n_reg - 4'd1;
            end
          end else if (t_reg == TW'(TIMEOUT_CYC - 1)) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            t_reg <= t_reg + TW'(1);
          end
        end
        CHECK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign overrun = rx_done_tick & full & ~rd_en;

  ps2_byte_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .wr   (rx_done_tick),
    .rd   (rd_en),
    .din  (b_reg[8:1]),
    .dout (dout),
    .empty(empty),
    .full (full)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: frame-level reference model plus directed frames.
module tb_ps2_rx_fifo;

  localparam int unsigned FL    = 8;
  localparam int unsigned TO    = 300;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned HALF  = 20;
`ifdef PS2_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       empty, full, rx_done_tick, parity_err, frame_err, timeout_err, overrun;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned n_done = 0, n_ferr = 0, n_perr = 0, n_terr = 0, n_ovr = 0;
  int unsigned done_cyc = 0, last_drop = 0;

  ps2_rx_fifo #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .rx_en       (rx_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .rx_done_tick(rx_done_tick),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: filtered clock from a sample history, frames as bit lists.
  bit         m_hist[$];
  bit         m_f, m_in, m_check, m_valid;
  bit         m_bits[$];
  int unsigned m_t;
  bit         e_done, e_ferr, e_perr, e_terr;
  logic [7:0] e_byte;
  logic [7:0] m_q[$];

  always @(posedge clk) begin : model
    bit fall, fnew, all1, all0;
    int ones;
    if (reset) begin
      m_hist.delete();
      for (int i = 0; i < FL; i++) m_hist.push_back(1'b0);
      m_f = 0; m_in = 0; m_check = 0; m_t = 0;
      m_bits.delete(); m_q.delete();
      e_done = 0; e_ferr = 0; e_perr = 0; e_terr = 0; e_byte = '0;
      m_valid = 1;
    end else begin
      if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (e_done && m_q.size() < DEPTH) m_q.push_back(e_byte);
      all1 = 1; all0 = 1;
      foreach (m_hist[i]) if (m_hist[i]) all0 = 0; else all1 = 0;
      fnew = all1 ? 1'b1 : (all0 ? 1'b0 : m_f);
      fall = m_f && !fnew;
      m_f  = fnew;
      void'(m_hist.pop_front());
      m_hist.push_back(ps2c);
      e_done = 0; e_ferr = 0; e_perr = 0; e_terr = 0;
      if (m_check) begin
        m_check = 0;
      end else if (!m_in) begin
        if (fall && rx_en && !ps2d) begin
          m_in = 1; m_t = 0; m_bits.delete();
        end
      end else if (fall) begin
        m_bits.push_back(ps2d);
        m_t = 0;
        if (m_bits.size() == 10) begin
          ones = 0;
          for (int i = 0; i < 9; i++) ones += int'(m_bits[i]);
          for (int i = 0; i < 8; i++) e_byte[i] = m_bits[i];
          e_ferr  = !m_bits[9];
          e_perr  = PAR_EN && (ones % 2 == 0);
          e_done  = !e_ferr && !e_perr;
          m_in    = 0;
          m_check = 1;
        end
      end else if (m_t == TO - 1) begin
        e_terr = 1; m_in = 0;
      end else begin
        m_t++;
      end
    end
  end

  always @(negedge clk) begin
    #4;
    if (m_valid) begin
      chk("rx_done_tick", rx_done_tick, e_done);
      chk("frame_err", frame_err, e_ferr);
      chk("parity_err", parity_err, e_perr);
      chk("timeout_err", timeout_err, e_terr);
      chk("overrun", overrun, e_done && m_q.size() == DEPTH && !rd_en);
      chk("empty", empty, m_q.size() == 0);
      chk("full", full, m_q.size() == DEPTH);
      if (m_q.size() > 0) chk("dout", dout, m_q[0]);
      if (rx_done_tick) begin n_done++; done_cyc = cyc; end
      if (frame_err)   n_ferr++;
      if (parity_err)  n_perr++;
      if (timeout_err) n_terr++;
      if (overrun)     n_ovr++;
    end
  end

  task automatic ps2_bit(input logic b, input bit pop_done);
    @(negedge clk); ps2d = b;
    repeat (HALF - 1) @(negedge clk);
    @(negedge clk); ps2c = 1'b0; last_drop = cyc;
    for (int i = 1; i < HALF; i++) begin
      @(negedge clk);
      rd_en = pop_done && (cyc == last_drop + FL + 1);
    end
    @(negedge clk); rd_en = 1'b0; ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input logic en, input bit drop_en, input bit pop_done);
    rx_en = en;
    ps2_bit(1'b0, 1'b0);
    if (drop_en) rx_en = 1'b0;
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
    ps2_bit(p, 1'b0);
    ps2_bit(s, pop_done);
    repeat (2 * HALF) @(negedge clk);
    rx_en = 1'b1;
    #1;
  endtask

  task automatic pop();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned d0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_empty", empty, 1'b1);
    chk("reset_full", full, 1'b0);
    chk("reset_dout", dout, 8'h00);
    chk("reset_done", rx_done_tick, 1'b0);
    @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 0, 0);
    chk("1c_done_cnt", n_done, 1);
    chk("1c_latency", done_cyc - last_drop, FL + 1);
    chk("1c_dout", dout, 8'h1C);
    chk("1c_empty", empty, 1'b0);
    pop();
    chk("1c_popped", empty, 1'b1);

    send_frame(8'hF0, 1'b0, 1'b1, 1'b1, 0, 0);
    chk("f0_perr_cnt", n_perr, PAR_EN ? 1 : 0);
    chk("f0_done_cnt", n_done, PAR_EN ? 1 : 2);
    chk("f0_empty", empty, PAR_EN);
    pop();

    d0 = n_done;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 0, 0);
    chk("stop0_ferr_cnt", n_ferr, 1);
    chk("stop0_no_done", n_done, d0);
    chk("stop0_empty", empty, 1'b1);

    @(negedge clk); ps2d = 1'b0; ps2c = 1'b0;
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (TO + 50) @(negedge clk);
    ps2d = 1'b1;
    #1;
    chk("glitch_no_timeout", n_terr, 0);
    chk("glitch_no_done", n_done, d0);

    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
    repeat (TO + 60) @(negedge clk);
    #1;
    chk("timeout_cnt", n_terr, 1);
    chk("timeout_empty", empty, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0, 0);
    chk("after_to_done", n_done, d0 + 1);
    chk("after_to_dout", dout, 8'hA5);
    pop();

    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("rx_dis_no_done", n_done, d0 + 1);
    chk("rx_dis_empty", empty, 1'b1);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1, 0);
    chk("rx_drop_mid_done", n_done, d0 + 2);
    chk("rx_drop_mid_dout", dout, 8'h81);
    pop();

    send_frame(8'h11, 1'b1, 1'b1, 1'b1, 0, 0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1, 0, 0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b1, 0, 0);
    chk("ovr_full", full, 1'b1);
    chk("ovr_cnt", n_ovr, 1);
    chk("ovr_pop1", dout, 8'h11);
    pop();
    chk("ovr_pop2", dout, 8'h22);
    pop();
    chk("ovr_drained", empty, 1'b1);

    send_frame(8'h11, 1'b1, 1'b1, 1'b1, 0, 0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1, 0, 0);
    send_frame(8'h44, 1'b1, 1'b1, 1'b1, 0, 1);
    chk("pushpop_no_ovr", n_ovr, 1);
    chk("pushpop_full", full, 1'b1);
    chk("pushpop_head", dout, 8'h22);
    pop();
    chk("pushpop_next", dout, 8'h44);
    pop();
    chk("pushpop_empty", empty, 1'b1);

    send_frame(8'h66, 1'b1, 1'b1, 1'b1, 0, 0);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("midreset_empty", empty, 1'b1);
    chk("midreset_dout", dout, 8'h00);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    d0 = n_done;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 0, 0);
    chk("post_reset_done", n_done, d0 + 1);
    chk("post_reset_dout", dout, 8'h1C);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
